// File: rtl/fifo_pkg.sv
// Shared FIFO-slice definitions: default word width / pack factor and the
// word and lane-mask types derived from them.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PACK_DEF = 4;

  typedef logic [DATA_WIDTH_DEF-1:0] word_t;
  typedef logic [PACK_DEF-1:0]       keep_t;

endpackage

// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO consumer: packs PACK show-ahead words (first popped in lane 0)
// into one valid/ready output word, with flush emitting a masked partial word.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK       = PACK_DEF
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic [DATA_WIDTH-1:0]      rdata,
  input  logic                       rempty,
  output logic                       rinc,
  input  logic                       flush,
  output logic [DATA_WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]            m_keep,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int CW = $clog2(PACK + 1);
  localparam logic [CW-1:0] ZERO_C = CW'(0);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] FULL_C = CW'(PACK);

  logic [PACK-1:0][DATA_WIDTH-1:0] acc_r;
  logic [CW-1:0]                   cnt_r;
  logic                            flush_pend_r;

  logic            full_s;
  logic            part_s;
  logic            hold_free_s;
  logic            xfer_s;
  logic            pop_s;
  logic [PACK-1:0] keep_s;

  function automatic logic [PACK-1:0] lane_mask(input logic [CW-1:0] n);
    logic [PACK-1:0] m;
    m = {PACK{1'b0}};
    for (int i = 0; i < PACK; i++) begin
      m[i] = (CW'(i) < n);
    end
    return m;
  endfunction

  // Transfer and pop decisions; a pop into a full accumulator is only
  // allowed when the same cycle moves the accumulator out.
  always_comb begin
    full_s      = (cnt_r == FULL_C);
    part_s      = flush_pend_r && (cnt_r != ZERO_C);
    hold_free_s = !m_valid || m_ready;
    xfer_s      = (full_s || part_s) && hold_free_s;
    pop_s       = !rrst && !rempty && !flush_pend_r && (!full_s || xfer_s);
    keep_s      = lane_mask(cnt_r);
  end

  assign rinc = pop_s;

  // Accumulator, lane count, flush tracking and output holding register.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      acc_r        <= {(PACK*DATA_WIDTH){1'b0}};
      cnt_r        <= ZERO_C;
      flush_pend_r <= 1'b0;
      m_data       <= {(PACK*DATA_WIDTH){1'b0}};
      m_keep       <= {PACK{1'b0}};
      m_last       <= 1'b0;
      m_valid      <= 1'b0;
    end else begin
      if (xfer_s) begin
        for (int i = 0; i < PACK; i++) begin
          m_data[i*DATA_WIDTH +: DATA_WIDTH] <= keep_s[i] ? acc_r[i] : {DATA_WIDTH{1'b0}};
        end
        m_keep  <= keep_s;
        m_last  <= flush_pend_r || flush;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      if (pop_s) begin
        if (xfer_s) begin
          acc_r[0] <= rdata;
          cnt_r    <= ONE_C;
        end else begin
          for (int i = 0; i < PACK; i++) begin
            if (cnt_r == CW'(i)) begin
              acc_r[i] <= rdata;
            end
          end
          cnt_r <= cnt_r + ONE_C;
        end
      end else if (xfer_s) begin
        cnt_r <= ZERO_C;
      end

      // An empty accumulator with no arriving word has nothing to flush.
      if (xfer_s) begin
        flush_pend_r <= 1'b0;
      end else if (flush && ((cnt_r != ZERO_C) || pop_s)) begin
        flush_pend_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a show-ahead FIFO model feeds the DUT and a
// negedge monitor records pops and accepted output words for checking.
module tb_fifo_rd_packer;
  import fifo_pkg::*;

  typedef struct packed {
    logic        last;
    logic [3:0]  keep;
    logic [31:0] data;
  } out_t;

  logic        rclk = 1'b0;
  logic        rrst;
  word_t       rdata;
  logic        rempty;
  logic        rinc;
  logic        flush;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;
  logic        gate_empty;

  word_t mem [256];
  int    wr_ptr = 0;
  int    rd_ptr = 0;
  int    cyc = 0;
  int    viol = 0;
  int    n_checks = 0;
  int    n_errors = 0;

  out_t out_q[$];
  int   out_cyc_q[$];
  int   pop_q[$];

  fifo_rd_packer #(.DATA_WIDTH(8), .PACK(4)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rdata   (rdata),
    .rempty  (rempty),
    .rinc    (rinc),
    .flush   (flush),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 rclk = ~rclk;

  // Show-ahead FIFO model: head word visible while not empty, advance on rinc.
  assign rdata  = mem[rd_ptr[7:0]];
  assign rempty = (rd_ptr == wr_ptr) || gate_empty;

  always @(posedge rclk) begin
    cyc <= cyc + 1;
    if (rinc) rd_ptr <= rd_ptr + 1;
  end

  // Monitor: pop cycles, empty-read violations and accepted output words.
  always @(negedge rclk) begin
    if (rinc && rempty) viol <= viol + 1;
    if (!rrst) begin
      if (rinc) pop_q.push_back(cyc);
      if (m_valid && m_ready) begin
        out_q.push_back({m_last, m_keep, m_data});
        out_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic push(input word_t d);
    mem[wr_ptr[7:0]] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check_out(input string tag, input int idx, input logic [31:0] d,
                           input logic [3:0] k, input logic l);
    if (idx < out_q.size()) begin
      check({tag, "_data"}, 64'(out_q[idx].data), 64'(d));
      check({tag, "_keep"}, 64'(out_q[idx].keep), 64'(k));
      check({tag, "_last"}, 64'(out_q[idx].last), 64'(l));
    end else begin
      check({tag, "_present"}, 64'(out_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic check_hold(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
    check({tag, "_valid"}, 64'(m_valid), 64'(1));
    check({tag, "_data"},  64'(m_data),  64'(d));
    check({tag, "_keep"},  64'(m_keep),  64'(k));
    check({tag, "_last"},  64'(m_last),  64'(l));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rinc"},  64'(rinc),    64'(0));
    check({tag, "_valid"}, 64'(m_valid), 64'(0));
    check({tag, "_data"},  64'(m_data),  64'(0));
    check({tag, "_keep"},  64'(m_keep),  64'(0));
    check({tag, "_last"},  64'(m_last),  64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ob;
    int pb;
    logic [31:0] exp_w;

    rrst = 1'b1; m_ready = 1'b0; flush = 1'b0; gate_empty = 1'b0;
    tick(3);
    check_zero("reset");

    // Four words, no backpressure; data present while reset is still held.
    m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    check("rinc_in_reset", 64'(rinc), 64'(0));
    ob = out_q.size(); pb = pop_q.size();
    rrst = 1'b0;
    tick(8);
    check("t1_pops", 64'(pop_q.size() - pb), 64'(4));
    if (pop_q.size() >= pb + 4) begin
      check("t1_pop_span", 64'(pop_q[pb+3] - pop_q[pb]), 64'(3));
      if (out_cyc_q.size() > ob)
        check("t1_latency", 64'(out_cyc_q[ob] - pop_q[pb+3]), 64'(2));
    end
    check("t1_words", 64'(out_q.size() - ob), 64'(1));
    check_out("t1", ob, 32'h44332211, 4'b1111, 1'b0);

    // Eight words back to back.
    ob = out_q.size(); pb = pop_q.size();
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(14);
    check("t2_pops", 64'(pop_q.size() - pb), 64'(8));
    if (pop_q.size() >= pb + 8)
      check("t2_pop_span", 64'(pop_q[pb+7] - pop_q[pb]), 64'(7));
    check("t2_words", 64'(out_q.size() - ob), 64'(2));
    check_out("t2a", ob, 32'h04030201, 4'b1111, 1'b0);
    check_out("t2b", ob + 1, 32'h08070605, 4'b1111, 1'b0);
    if (out_cyc_q.size() >= ob + 2)
      check("t2_spacing", 64'(out_cyc_q[ob+1] - out_cyc_q[ob]), 64'(4));

    // Backpressure: first word held, accumulator fills, pops stop.
    m_ready = 1'b0;
    pb = pop_q.size();
    for (int i = 1; i <= 8; i++) push(8'(i));
    tick(14);
    check("t3_pops", 64'(pop_q.size() - pb), 64'(8));
    check_hold("t3_hold", 32'h04030201, 4'b1111, 1'b0);
    tick(3);
    check_hold("t3_stable", 32'h04030201, 4'b1111, 1'b0);
    push(8'h09);
    #1;
    check("t3_rinc_blocked", 64'(rinc), 64'(0));
    m_ready = 1'b1;
    #1;
    check("t3_rinc_resume", 64'(rinc), 64'(1));
    @(posedge rclk); #1;
    check_hold("t3_second", 32'h08070605, 4'b1111, 1'b0);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    check("t3_flush_gap", 64'(m_valid), 64'(0));
    tick(1);
    check_hold("t3_flush", 32'h00000009, 4'b0001, 1'b1);

    // Flush of a two-lane partial word.
    tick(2);
    push(8'hAA); push(8'hBB);
    tick(3);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(1);
    check_hold("t4_partial", 32'h0000BBAA, 4'b0011, 1'b1);

    // Flush with an empty accumulator is dropped.
    tick(2);
    ob = out_q.size();
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(3);
    check("t4_drop_words", 64'(out_q.size() - ob), 64'(0));
    check("t4_drop_valid", 64'(m_valid), 64'(0));

    // Flush coincident with the third pop includes that word.
    push(8'hAA); push(8'hBB);
    tick(3);
    push(8'hCC);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(1);
    check_hold("t4_coinc", 32'h00CCBBAA, 4'b0111, 1'b1);

    // Flush completing exactly a full word.
    tick(2);
    push(8'hA1); push(8'hA2); push(8'hA3);
    tick(4);
    push(8'hA4);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(1);
    check_hold("t4_full", 32'hA4A3A2A1, 4'b1111, 1'b1);

    // Reset mid-word and during a held output word.
    tick(2);
    push(8'h55); push(8'h66);
    tick(3);
    rrst = 1'b1;
    #1;
    check_zero("t5_rst_midword");
    tick(2);
    wr_ptr = rd_ptr;
    rrst = 1'b0;
    m_ready = 1'b0;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    tick(6);
    check("t5_held_valid", 64'(m_valid), 64'(1));
    rrst = 1'b1;
    #1;
    check_zero("t5_rst_held");
    tick(2);
    wr_ptr = rd_ptr;
    rrst = 1'b0;
    m_ready = 1'b1;
    ob = out_q.size();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    tick(8);
    check("t5_words", 64'(out_q.size() - ob), 64'(1));
    check_out("t5", ob, 32'h44332211, 4'b1111, 1'b0);

    // Random empty gating and backpressure over sixteen words.
    ob = out_q.size();
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    for (int c = 0; c < 400 && out_q.size() < ob + 4; c++) begin
      gate_empty = ($urandom_range(0, 1) == 1);
      m_ready    = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    gate_empty = 1'b0;
    m_ready = 1'b1;
    check("t6_words", 64'(out_q.size() - ob), 64'(4));
    for (int j = 0; j < 4; j++) begin
      for (int b = 0; b < 4; b++) exp_w[8*b +: 8] = 8'(8'h80 + 4*j + b);
      check_out("t6", ob + j, exp_w, 4'b1111, 1'b0);
    end
    tick(2);
    check("empty_read_violations", 64'(viol), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
